// File: rtl/pma_region_table.sv
// Run-time programmable physical-memory-attribute table: NrRules writable
// {base, length, attr} rules with a request/grant config port and a registered lookup.
module pma_region_table #(
  parameter int unsigned NrRules   = 8,
  parameter int unsigned AddrWidth = 64,
  parameter logic [NrRules-1:0][AddrWidth-1:0] RstBase   = '0,
  parameter logic [NrRules-1:0][AddrWidth-1:0] RstLength = '0,
  parameter logic [NrRules-1:0][3:0]           RstAttr   = '0,
  localparam int unsigned IdxW = (NrRules > 1) ? $clog2(NrRules) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_req_i,
  input  logic                 cfg_we_i,
  input  logic [IdxW+1:0]      cfg_addr_i,
  input  logic [AddrWidth-1:0] cfg_wdata_i,
  output logic                 cfg_gnt_o,
  output logic                 cfg_rvalid_o,
  output logic [AddrWidth-1:0] cfg_rdata_o,
  output logic                 cfg_err_o,
  input  logic                 lookup_valid_i,
  input  logic [AddrWidth-1:0] lookup_addr_i,
  output logic                 lookup_valid_o,
  output logic                 lookup_hit_o,
  output logic [IdxW-1:0]      lookup_idx_o,
  output logic                 cached_o,
  output logic                 nonidem_o,
  output logic                 exec_o
);

  // attr bit layout: [3] lock, [2] exec, [1] nonidem, [0] cached
  logic [AddrWidth-1:0] base_q [NrRules];
  logic [AddrWidth-1:0] len_q  [NrRules];
  logic [3:0]           attr_q [NrRules];

  logic [IdxW-1:0]      cfg_idx;
  logic [1:0]           cfg_field;
  logic                 idx_ok;
  logic                 sel_lock;
  logic [AddrWidth-1:0] sel_rd;
  logic                 cfg_err_d;
  logic                 wr_en;
  logic [AddrWidth-1:0] cfg_rdata_d;

  logic                 lk_hit;
  logic [IdxW-1:0]      lk_idx;
  logic [2:0]           lk_attr;

  assign cfg_idx   = cfg_addr_i[IdxW+1:2];
  assign cfg_field = cfg_addr_i[1:0];
  assign cfg_gnt_o = cfg_req_i & ~rst_i;

  always_comb begin
    idx_ok   = 1'b0;
    sel_lock = 1'b0;
    sel_rd   = '0;
    for (int unsigned i = 0; i < NrRules; i++) begin
      if (cfg_idx == IdxW'(i)) begin
        idx_ok   = 1'b1;
        sel_lock = attr_q[i][3];
        case (cfg_field)
          2'd0:    sel_rd = base_q[i];
          2'd1:    sel_rd = len_q[i];
          2'd2:    sel_rd = AddrWidth'(attr_q[i]);
          default: sel_rd = '0;
        endcase
      end
    end
    cfg_err_d   = !idx_ok || (cfg_we_i && (cfg_field == 2'd3 || sel_lock));
    wr_en       = cfg_req_i && cfg_we_i && !cfg_err_d;
    cfg_rdata_d = (!cfg_we_i && !cfg_err_d) ? sel_rd : '0;
  end

  // Lock stays set: once bit 3 is 1 every write to the rule is rejected.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NrRules; i++) begin
        base_q[i] <= RstBase[i];
        len_q[i]  <= RstLength[i];
        attr_q[i] <= RstAttr[i];
      end
    end else if (wr_en) begin
      for (int unsigned i = 0; i < NrRules; i++) begin
        if (cfg_idx == IdxW'(i)) begin
          case (cfg_field)
            2'd0:    base_q[i] <= cfg_wdata_i;
            2'd1:    len_q[i]  <= cfg_wdata_i;
            2'd2:    attr_q[i] <= cfg_wdata_i[3:0];
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cfg_rvalid_o <= 1'b0;
      cfg_err_o    <= 1'b0;
      cfg_rdata_o  <= '0;
    end else begin
      cfg_rvalid_o <= cfg_req_i;
      cfg_err_o    <= cfg_req_i & cfg_err_d;
      cfg_rdata_o  <= cfg_req_i ? cfg_rdata_d : '0;
    end
  end

  // Bound sum is one bit wider so a rule ending at the top of memory does not wrap.
  always_comb begin
    lk_hit  = 1'b0;
    lk_idx  = '0;
    lk_attr = '0;
    for (int unsigned i = 0; i < NrRules; i++) begin
      if (!lk_hit && len_q[i] != '0 && lookup_addr_i >= base_q[i] &&
          {1'b0, lookup_addr_i} < ({1'b0, base_q[i]} + {1'b0, len_q[i]})) begin
        lk_hit  = 1'b1;
        lk_idx  = IdxW'(i);
        lk_attr = attr_q[i][2:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lookup_valid_o <= 1'b0;
      lookup_hit_o   <= 1'b0;
      lookup_idx_o   <= '0;
      cached_o       <= 1'b0;
      nonidem_o      <= 1'b0;
      exec_o         <= 1'b0;
    end else begin
      lookup_valid_o <= lookup_valid_i;
      if (lookup_valid_i) begin
        lookup_hit_o <= lk_hit;
        lookup_idx_o <= lk_idx;
        cached_o     <= lk_attr[0];
        nonidem_o    <= lk_attr[1];
        exec_o       <= lk_attr[2];
      end
    end
  end

endmodule

// File: tb/tb_pma_region_table.sv
// Directed bench for pma_region_table; expected responses are queued when a
// request is driven and compared when the registered response appears.
module tb_pma_region_table;
  // Six rules leaves indices 6 and 7 encodable but out of range.
  localparam int unsigned NR = 6;
  localparam int unsigned AW = 64;
  localparam int unsigned IW = 3;
  localparam logic [NR-1:0][AW-1:0] RB = {{(NR-1){64'h0}}, 64'h8000_0000};
  localparam logic [NR-1:0][AW-1:0] RL = {{(NR-1){64'h0}}, 64'h4000_0000};
  localparam logic [NR-1:0][3:0]    RA = {{(NR-1){4'h0}}, 4'b0101};

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_req, cfg_we;
  logic [IW+1:0] cfg_addr;
  logic [AW-1:0] cfg_wdata;
  logic          cfg_gnt, cfg_rvalid, cfg_err;
  logic [AW-1:0] cfg_rdata;
  logic          lk_valid_in;
  logic [AW-1:0] lk_addr;
  logic          lk_valid_out, lk_hit, cached, nonidem, exec_a;
  logic [IW-1:0] lk_idx;

  typedef struct packed {logic err; logic [AW-1:0] rdata;} cfg_exp_t;
  typedef struct packed {logic hit; logic [IW-1:0] idx; logic c; logic n; logic x;} lk_exp_t;

  cfg_exp_t cq[$];
  lk_exp_t  lq[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pma_region_table #(
    .NrRules(NR), .AddrWidth(AW), .RstBase(RB), .RstLength(RL), .RstAttr(RA)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cfg_req_i(cfg_req), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr),
    .cfg_wdata_i(cfg_wdata), .cfg_gnt_o(cfg_gnt), .cfg_rvalid_o(cfg_rvalid),
    .cfg_rdata_o(cfg_rdata), .cfg_err_o(cfg_err),
    .lookup_valid_i(lk_valid_in), .lookup_addr_i(lk_addr),
    .lookup_valid_o(lk_valid_out), .lookup_hit_o(lk_hit), .lookup_idx_o(lk_idx),
    .cached_o(cached), .nonidem_o(nonidem), .exec_o(exec_a)
  );

  task automatic chk(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic put_wr(input int unsigned idx, input logic [1:0] field,
                        input logic [AW-1:0] data, input logic err);
    logic [IW-1:0] ib;
    ib        = IW'(idx);
    cfg_req   = 1'b1;
    cfg_we    = 1'b1;
    cfg_addr  = {ib, field};
    cfg_wdata = data;
    cq.push_back('{err: err, rdata: '0});
  endtask

  task automatic put_rd(input int unsigned idx, input logic [1:0] field,
                        input logic [AW-1:0] data, input logic err);
    logic [IW-1:0] ib;
    ib        = IW'(idx);
    cfg_req   = 1'b1;
    cfg_we    = 1'b0;
    cfg_addr  = {ib, field};
    cfg_wdata = '0;
    cq.push_back('{err: err, rdata: data});
  endtask

  // attr given as {exec, nonidem, cached}
  task automatic put_lk(input logic [AW-1:0] addr, input logic hit,
                        input int unsigned idx, input logic [2:0] attr);
    lk_valid_in = 1'b1;
    lk_addr     = addr;
    lq.push_back('{hit: hit, idx: IW'(idx), c: attr[0], n: attr[1], x: attr[2]});
  endtask

  task automatic tick();
    cfg_exp_t ce;
    lk_exp_t  le;
    #1;
    chk("gnt", AW'(cfg_gnt), AW'(cfg_req & ~rst));
    @(posedge clk);
    #1;
    chk("cfg_rvalid", AW'(cfg_rvalid), AW'(cq.size() != 0));
    if (cq.size() != 0) begin
      ce = cq.pop_front();
      chk("cfg_rdata", cfg_rdata, ce.rdata);
      chk("cfg_err", AW'(cfg_err), AW'(ce.err));
    end
    chk("lookup_valid", AW'(lk_valid_out), AW'(lq.size() != 0));
    if (lq.size() != 0) begin
      le = lq.pop_front();
      chk("lookup_hit", AW'(lk_hit), AW'(le.hit));
      chk("lookup_idx", AW'(lk_idx), AW'(le.idx));
      chk("cached", AW'(cached), AW'(le.c));
      chk("nonidem", AW'(nonidem), AW'(le.n));
      chk("exec", AW'(exec_a), AW'(le.x));
    end
    cfg_req     = 1'b0;
    cfg_we      = 1'b0;
    lk_valid_in = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_req = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    lk_valid_in = 1'b0; lk_addr = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_rdata", cfg_rdata, '0);
    chk("rst_err", AW'(cfg_err), '0);
    chk("rst_hit", AW'(lk_hit), '0);
    chk("rst_idx", AW'(lk_idx), '0);
    chk("rst_attr", AW'({exec_a, nonidem, cached}), '0);

    // reset-loaded rule 0
    put_rd(0, 2'd2, 64'h5, 1'b0);          tick();
    put_rd(0, 2'd0, 64'h8000_0000, 1'b0);  tick();
    put_rd(0, 2'd1, 64'h4000_0000, 1'b0);  tick();

    // range boundaries, one lookup per cycle
    put_lk(64'h8000_0000, 1'b1, 0, 3'b101); tick();
    put_lk(64'hBFFF_FFFF, 1'b1, 0, 3'b101); tick();
    put_lk(64'hC000_0000, 1'b0, 0, 3'b000); tick();
    put_lk(64'h7FFF_FFFF, 1'b0, 0, 3'b000); tick();

    // result holds while lookup_valid_i is low
    put_lk(64'h8000_0004, 1'b1, 0, 3'b101); tick();
    tick();
    chk("hold_hit", AW'(lk_hit), 64'h1);
    chk("hold_idx", AW'(lk_idx), 64'h0);
    chk("hold_attr", AW'({exec_a, nonidem, cached}), 64'h5);

    // overlap priority
    put_wr(1, 2'd0, 64'h1000, 1'b0);  tick();
    put_wr(1, 2'd1, 64'h1000, 1'b0);  tick();
    put_wr(1, 2'd2, 64'h2, 1'b0);     tick();
    put_wr(3, 2'd0, 64'h0, 1'b0);     tick();
    put_wr(3, 2'd1, 64'h10000, 1'b0); tick();
    put_wr(3, 2'd2, 64'h1, 1'b0);     tick();
    put_lk(64'h1800, 1'b1, 1, 3'b010); tick();
    put_lk(64'h3000, 1'b1, 3, 3'b001); tick();
    put_lk(64'h1000, 1'b1, 1, 3'b010); tick();
    put_lk(64'h0FFF, 1'b1, 3, 3'b001); tick();
    put_lk(64'h2000, 1'b1, 3, 3'b001); tick();

    // write and lookup in the same cycle
    put_wr(0, 2'd1, 64'h100, 1'b0); tick();
    put_wr(0, 2'd1, 64'h0, 1'b0);
    put_lk(64'h8000_0010, 1'b1, 0, 3'b101); tick();
    put_lk(64'h8000_0010, 1'b0, 0, 3'b000); tick();
    put_rd(0, 2'd1, 64'h0, 1'b0); tick();

    // out-of-range index and reserved field
    put_rd(6, 2'd0, 64'h0, 1'b1);  tick();
    put_wr(7, 2'd0, 64'h55, 1'b1); tick();
    put_rd(0, 2'd3, 64'h0, 1'b0);  tick();
    put_wr(0, 2'd3, 64'h1, 1'b1);  tick();

    // lock
    put_wr(2, 2'd2, 64'h9, 1'b0);    tick();
    put_rd(2, 2'd2, 64'h9, 1'b0);    tick();
    put_wr(2, 2'd0, 64'h2000, 1'b1); tick();
    put_rd(2, 2'd0, 64'h0, 1'b0);    tick();
    put_wr(2, 2'd2, 64'h0, 1'b1);    tick();
    put_rd(2, 2'd2, 64'h9, 1'b0);    tick();

    // reset with a read and a lookup in flight: nothing comes back
    rst = 1'b1;
    cfg_req = 1'b1; cfg_we = 1'b0; cfg_addr = {3'd0, 2'd2};
    lk_valid_in = 1'b1; lk_addr = 64'h8000_0000;
    tick();
    rst = 1'b0;
    put_rd(2, 2'd2, 64'h0, 1'b0);    tick();
    put_wr(2, 2'd0, 64'h2000, 1'b0); tick();
    put_rd(2, 2'd0, 64'h2000, 1'b0); tick();
    put_lk(64'h1800, 1'b0, 0, 3'b000);      tick();
    put_lk(64'h8000_0010, 1'b1, 0, 3'b101); tick();

    // top-of-memory rule must not wrap
    put_wr(4, 2'd0, 64'hFFFF_FFFF_FFFF_F000, 1'b0); tick();
    put_wr(4, 2'd1, 64'h2000, 1'b0);                tick();
    put_wr(4, 2'd2, 64'h4, 1'b0);                   tick();
    put_lk(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4, 3'b100); tick();
    put_lk(64'hFFFF_FFFF_FFFF_F000, 1'b1, 4, 3'b100); tick();
    put_lk(64'hFFFF_FFFF_FFFF_EFFF, 1'b0, 0, 3'b000); tick();
    put_lk(64'h0, 1'b0, 0, 3'b000);                   tick();
    tick();
    chk("sb_drained", AW'(cq.size() + lq.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pma_region_table.md
# pma_region_table

Run-time programmable physical-memory-attribute table that replaces the fixed cached, non-idempotent and execute region rule lists with NrRules writable rules. Each rule holds a base, a length, attribute bits and a lock bit. The block sits beside the MMU/PMP path. Software programs it through a simple request/grant register port. Fetch and LSU address checks query it through a registered one-cycle lookup port.

## Interface
Parameters:
- NrRules, 8: number of rules, 1..16.
- AddrWidth, 64: physical address width of base, length and lookup address.
- RstBase, all zero: NrRules x AddrWidth reset base values.
- RstLength, all zero: NrRules x AddrWidth reset lengths. Length 0 disables the rule.
- RstAttr, all zero: NrRules x 4 reset attributes {lock, exec, nonidem, cached}.

Ports:
- clk_i, in, 1: clock; all logic on the rising edge.
- rst_i, in, 1: reset, synchronous, active-high.
- cfg_req_i, in, 1: config access request.
- cfg_we_i, in, 1: 1 = write, 0 = read.
- cfg_addr_i, in, $clog2(NrRules)+2: {rule index, field}. Field 0 = base, 1 = length, 2 = attr, 3 = reserved.
- cfg_wdata_i, in, AddrWidth: write data. For attr, bits [3:0] are used.
- cfg_gnt_o, out, 1: request accepted, same cycle.
- cfg_rvalid_o, out, 1: response valid, one cycle after grant.
- cfg_rdata_o, out, AddrWidth: read data, valid with cfg_rvalid_o.
- cfg_err_o, out, 1: access error, valid with cfg_rvalid_o.
- lookup_valid_i, in, 1: lookup request.
- lookup_addr_i, in, AddrWidth: address to classify.
- lookup_valid_o, out, 1: result valid.
- lookup_hit_o, out, 1: some enabled rule matched.
- lookup_idx_o, out, $clog2(NrRules): index of the matching rule.
- cached_o, out, 1: matched rule attribute.
- nonidem_o, out, 1: matched rule attribute.
- exec_o, out, 1: matched rule attribute.

## Operation
Reset:
- Rule registers load RstBase, RstLength and RstAttr.
- All outputs are 0.

Config port:
- cfg_gnt_o = cfg_req_i whenever no reset is active, so there is no back-pressure.
- A write to an unlocked rule updates the addressed field at the clock edge of the grant.
- A write is ignored and sets cfg_err_o in either case:
  - the rule's lock bit is 1 (applies to all fields, including attr);
  - the field is 3.
- A rule index ≥ NrRules is an error, for both reads and writes.
- Reads return the zero-extended field.
  - Erroring reads return 0.
  - Field 3 reads return 0 with no error.
- Setting lock is one-way. Only rst_i clears it.

Lookup:
- Rule i matches when both hold:
  - RstLength/current length ≠ 0;
  - base ≤ addr < base + length, with the sum computed in AddrWidth+1 bits so it does not wrap.
- Priority: the lowest matching index wins. lookup_idx_o reports that index.
- On a miss:
  - lookup_hit_o = 0, cached_o = 0, nonidem_o = 0, exec_o = 0, lookup_idx_o = 0.
  - Consumers treat a miss as uncached, non-executable, idempotent.
- Result registers update only when lookup_valid_i is high. lookup_valid_o is lookup_valid_i delayed by one cycle.
- When lookup_valid_i is low, the result outputs hold their previous values.

## Timing
- Config response: cfg_rvalid_o, cfg_rdata_o and cfg_err_o are registered, one cycle after grant, and pulse for one cycle.
- Back-to-back requests are accepted every cycle.
- Lookup latency is 1 cycle, fully pipelined at one lookup per cycle.
- A config write and a lookup in the same cycle: the lookup sees pre-write rule values. The following cycle sees the new values.
- A read and a write to the same field are never simultaneous (single port). A read issued the cycle after a write returns the new value.
- rst_i asserted mid-access:
  - pending cfg_rvalid_o and lookup_valid_o are dropped (0 the next cycle);
  - rules return to reset values, locks cleared.
- Comparison is purely combinational before the result register. There is no multi-cycle path.

## Test plan
1. Reset then read. Reset with RstBase[0]=0x8000_0000, RstLength[0]=0x4000_0000, RstAttr[0]=0b0101, then read {0,2} → cfg_rvalid_o one cycle later, cfg_rdata_o=0x5, cfg_err_o=0.
2. Range boundaries. Using the reset rule from test 1, lookup 0x8000_0000 → hit, idx 0, cached=1, exec=1. Lookup 0xBFFF_FFFF → hit. Lookup 0xC000_0000 → miss, all attributes 0.
3. Overlap priority.
   - Setup: rule 1 = [0x1000, +0x1000) with nonidem; rule 3 = [0x0, +0x10000) with cached.
   - Lookup 0x1800 → idx 1, nonidem=1, cached=0.
   - Lookup 0x3000 → idx 3, cached=1.
4. Lock.
   - Write attr of rule 2 = 0b1001.
   - Write base of rule 2 = 0x2000 → cfg_err_o=1 and base unchanged on readback.
   - Pulse rst_i → lock cleared; the same base write then succeeds with err=0.
5. Wrap and overflow. base=0xFFFF_FFFF_FFFF_F000, length=0x2000. Lookup 0xFFFF_FFFF_FFFF_FFFF → hit. Lookup 0x0 → miss (no wrap).
6. Same-cycle write and lookup.
   - Rule 0 length is 0x100. In the same cycle, write rule 0 length=0 and issue a lookup of base+0x10 → hit.
   - An identical lookup the next cycle → miss.
   - Index 8 with NrRules=8 → err=1, rdata=0.
